// File: rtl/vga_scan_driver.sv
// VGA scan driver: pixel-rate h/v counters exposed as x/y, plus registered colour and sync
// outputs captured on the last clk of each pixel period, and frame_start/move strobes.
module vga_scan_driver #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned MOVE_FRAMES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_clk,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank_n,
  output logic       frame_start,
  output logic       move
);

  localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);
  localparam logic [9:0] HLast      = 10'(HTotal - 1);
  localparam logic [9:0] VLast      = 10'(VTotal - 1);
  localparam logic [9:0] HVis       = 10'(H_VISIBLE);
  localparam logic [9:0] VVis       = 10'(V_VISIBLE);
  localparam logic [9:0] HSyncFirst = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HSyncLast  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VSyncFirst = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VSyncLast  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [7:0] FrameLast  = 8'(MOVE_FRAMES - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      h_q, h_d, v_q, v_d;
  logic [7:0]      frame_q, frame_d;
  logic [23:0]     rgb_q, rgb_d;
  logic            vga_clk_q, vga_clk_d;
  logic            hsync_n_q, hsync_n_d;
  logic            vsync_n_q, vsync_n_d;
  logic            blank_n_q, blank_n_d;
  logic            frame_start_q, frame_start_d;
  logic            move_q, move_d;
  logic            pix_en, vis, h_wrap, v_wrap;

  assign pix_en = (div_q == DivLast);
  assign vis    = (h_q < HVis) && (v_q < VVis);
  assign h_wrap = (h_q == HLast);
  assign v_wrap = (v_q == VLast);

  always_comb begin
    div_d         = pix_en ? '0 : div_q + DivW'(1);
    h_d           = h_q;
    v_d           = v_q;
    frame_d       = frame_q;
    rgb_d         = rgb_q;
    hsync_n_d     = hsync_n_q;
    vsync_n_d     = vsync_n_q;
    blank_n_d     = blank_n_q;
    frame_start_d = 1'b0;
    move_d        = 1'b0;
    // Registered so that vga_clk is high exactly while div_q is in the upper half.
    vga_clk_d     = (div_d >= DivHalf);

    if (pix_en) begin
      h_d = h_wrap ? 10'd0 : h_q + 10'd1;
      if (h_wrap) begin
        v_d = v_wrap ? 10'd0 : v_q + 10'd1;
      end
      // Capture uses the pixel being retired, not the one about to start.
      rgb_d         = vis ? {r, g, b} : 24'd0;
      blank_n_d     = vis;
      hsync_n_d     = !((h_q >= HSyncFirst) && (h_q <= HSyncLast));
      vsync_n_d     = !((v_q >= VSyncFirst) && (v_q <= VSyncLast));
      frame_start_d = h_wrap && v_wrap;
      if ((h_q == 10'd0) && (v_q == VVis)) begin
        if (frame_q == FrameLast) begin
          frame_d = 8'd0;
          move_d  = 1'b1;
        end else begin
          frame_d = frame_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q         <= '0;
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      frame_q       <= 8'd0;
      rgb_q         <= 24'd0;
      vga_clk_q     <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
      move_q        <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      frame_q       <= frame_d;
      rgb_q         <= rgb_d;
      vga_clk_q     <= vga_clk_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
      move_q        <= move_d;
    end
  end

  assign x           = h_q;
  assign y           = v_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign vga_clk     = vga_clk_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign blank_n     = blank_n_q;
  assign frame_start = frame_start_q;
  assign move        = move_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver with a shrunken raster; expectations come from the elapsed
// clock count since reset release, decomposed arithmetically into pixel, line and frame.
module tb_vga_scan_driver;

  localparam int D   = 2;
  localparam int HV  = 16;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HBP = 3;
  localparam int VV  = 10;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int MF  = 3;
  localparam int HT  = HV + HFP + HS + HBP;
  localparam int VT  = VV + VFP + VS + VBP;
  localparam int FT  = D * HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] r = 8'd0, g = 8'd0, b = 8'd0;
  logic [9:0] x, y;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_clk, hsync_n, vsync_n, blank_n, frame_start, move;

  vga_scan_driver #(
    .CLK_DIV(D), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .MOVE_FRAMES(MF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .r(r), .g(g), .b(b), .x(x), .y(y),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_clk(vga_clk),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .blank_n(blank_n),
    .frame_start(frame_start), .move(move)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          u = 0;          // clocks elapsed since the last reset edge
  logic [23:0] exp_col = 24'd0;
  bit          rgb_ff = 1'b1;
  int          hs_run = 0;
  int          move_cnt = 0;
  int          fs_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at u=%0d: got %0h expected %0h", tag, u, got, exp);
    end
  endtask

  function automatic bit pix_vis(input int p);
    return ((p % HT) < HV) && (((p / HT) % VT) < VV);
  endfunction

  // One clock: update the model at the edge, check at the falling edge, then drive inputs.
  task automatic step();
    int p;
    @(posedge clk);
    if (!rst_n) begin
      u       = 0;
      exp_col = 24'd0;
      hs_run  = 0;
    end else begin
      if ((u % D) == D - 1) exp_col = pix_vis(u / D) ? {r, g, b} : 24'd0;
      u++;
    end
    @(negedge clk);
    check_eq("x", 32'(x), 32'((u / D) % HT));
    check_eq("y", 32'(y), 32'(((u / D) / HT) % VT));
    check_eq("vga_clk", 32'(vga_clk), 32'((u % D) >= D / 2));
    check_eq("rgb", {8'd0, vga_r, vga_g, vga_b}, {8'd0, exp_col});
    if (u < D) begin
      check_eq("blank_n", 32'(blank_n), 32'd0);
      check_eq("hsync_n", 32'(hsync_n), 32'd1);
      check_eq("vsync_n", 32'(vsync_n), 32'd1);
    end else begin
      p = u / D - 1;
      check_eq("blank_n", 32'(blank_n), 32'(pix_vis(p)));
      check_eq("hsync_n", 32'(hsync_n),
               32'(!(((p % HT) >= HV + HFP) && ((p % HT) <= HV + HFP + HS - 1))));
      check_eq("vsync_n", 32'(vsync_n),
               32'(!((((p / HT) % VT) >= VV + VFP) && (((p / HT) % VT) <= VV + VFP + VS - 1))));
    end
    check_eq("frame_start", 32'(frame_start), 32'((u > 0) && ((u % FT) == 0)));
    check_eq("move", 32'(move),
             32'((u >= D) && (((u - D) % FT) == VV * HT * D) && ((((u - D) / FT) + 1) % MF == 0)));
    if (!hsync_n) begin
      hs_run++;
    end else if (hs_run > 0) begin
      check_eq("hsync_width", 32'(hs_run), 32'(HS * D));
      hs_run = 0;
    end
    if (move) move_cnt++;
    if (frame_start) fs_cnt++;
    if (rgb_ff) begin
      r = 8'hFF; g = 8'hFF; b = 8'hFF;
    end else begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (5) step();
    rst_n = 1'b1;
    move_cnt = 0;
    fs_cnt   = 0;
    repeat (FT) step();
    rgb_ff = 1'b0;
    repeat (6 * FT) step();
    check_eq("move_pulses_7_frames", 32'(move_cnt), 32'd2);
    check_eq("frame_starts_7_frames", 32'(fs_cnt), 32'd7);

    // Reset in the middle of a sync pulse, then at random points.
    repeat (FT / 2) step();
    for (int k = 0; k < 4 * FT && ((u / D) % HT) != HV + HFP + 1; k++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(FT, 50)) step();
      rst_n = 1'b0;
      repeat ($urandom_range(3, 1)) step();
      rst_n = 1'b1;
    end
    repeat (2 * FT) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
